// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, opcodes and fetch-stage types
package riscv_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Instruction addresses are word aligned; low two bits are dropped
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage with hold buffer and redirect drain
module instruction_fetch
    import riscv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        succ
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_fetch_addr, w_fetch_addr_nxt;
    logic [31:0]  r_hold_instr, w_hold_instr_nxt;
    logic [31:0]  r_hold_pc, w_hold_pc_nxt;
    logic [31:0]  r_instr, w_instr_nxt;
    logic [31:0]  r_pc_out, w_pc_out_nxt;
    logic         r_succ, w_succ_nxt;
    logic [31:0]  w_redirect_target;
    logic         w_redirect_to_fetch;

    assign w_redirect_target = align_word(redirect_pc);

    // A redirect may retarget immediately only when no request is left unacknowledged
    assign w_redirect_to_fetch = (r_state == ST_HELD) || imem_ready;

    // Request is dropped while reset is held so memory never sees a stale request
    assign imem_req  = reset && (r_state != ST_HELD);
    assign imem_addr = r_fetch_addr;
    assign instr_out = r_instr;
    assign pc_out    = r_pc_out;
    assign succ      = r_succ;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= 32'd0;
            r_instr      <= NOP_INSTR;
            r_pc_out     <= 32'd0;
            r_succ       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_addr <= w_fetch_addr_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_succ       <= w_succ_nxt;
        end
    end

    // Next-state and output decode; redirect is applied last so it overrides stall
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fetch_addr_nxt = r_fetch_addr;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_instr_nxt      = r_instr;
        w_pc_out_nxt     = r_pc_out;
        w_succ_nxt       = r_succ;

        case (r_state)
            ST_FETCH: begin
                if (imem_ready && !stall) begin
                    w_instr_nxt      = imem_rdata;
                    w_pc_out_nxt     = r_fetch_addr;
                    w_succ_nxt       = 1'b0;
                    w_fetch_addr_nxt = r_fetch_addr + 32'd4;
                    w_pc_nxt         = r_fetch_addr + 32'd4;
                end else if (imem_ready && stall) begin
                    w_hold_instr_nxt = imem_rdata;
                    w_hold_pc_nxt    = r_fetch_addr;
                    w_state_nxt      = ST_HELD;
                end else if (!stall) begin
                    w_instr_nxt  = NOP_INSTR;
                    w_pc_out_nxt = 32'd0;
                    w_succ_nxt   = 1'b1;
                end
            end
            ST_HELD: begin
                if (!stall) begin
                    w_instr_nxt      = r_hold_instr;
                    w_pc_out_nxt     = r_hold_pc;
                    w_succ_nxt       = 1'b0;
                    w_fetch_addr_nxt = r_hold_pc + 32'd4;
                    w_pc_nxt         = r_hold_pc + 32'd4;
                    w_state_nxt      = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The response for the abandoned address is consumed and thrown away
                w_instr_nxt  = NOP_INSTR;
                w_pc_out_nxt = 32'd0;
                w_succ_nxt   = 1'b1;
                if (imem_ready) begin
                    w_fetch_addr_nxt = r_pc;
                    w_state_nxt      = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        if (redirect) begin
            w_pc_nxt         = w_redirect_target;
            w_instr_nxt      = NOP_INSTR;
            w_pc_out_nxt     = 32'd0;
            w_succ_nxt       = 1'b1;
            w_hold_instr_nxt = NOP_INSTR;
            w_hold_pc_nxt    = 32'd0;
            if (w_redirect_to_fetch) begin
                w_fetch_addr_nxt = w_redirect_target;
                w_state_nxt      = ST_FETCH;
            end else begin
                w_fetch_addr_nxt = r_fetch_addr;
                w_state_nxt      = ST_DRAIN;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] T_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] T_NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        succ;

    int checks = 0;
    int failures = 0;

    // reference model: transaction-level flags, not the RTL state encoding
    logic [31:0] m_addr, m_target, m_hword, m_hpc, m_instr, m_pcout;
    logic        m_held, m_drain, m_bubble;

    instruction_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .succ        (succ)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0003;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic model_reset();
        m_addr = T_RESET_PC; m_target = T_RESET_PC;
        m_held = 1'b0; m_drain = 1'b0; m_hword = 32'd0; m_hpc = 32'd0;
        m_instr = T_NOP; m_pcout = 32'd0; m_bubble = 1'b1;
    endtask

    task automatic model_bubble();
        m_instr = T_NOP; m_pcout = 32'd0; m_bubble = 1'b1;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (redirect) begin
            model_bubble();
            if (m_held || imem_ready) begin
                m_addr = tgt; m_drain = 1'b0;
            end else begin
                m_drain = 1'b1;
            end
            m_held = 1'b0;
            m_target = tgt;
        end else if (m_held) begin
            if (!stall) begin
                m_instr = m_hword; m_pcout = m_hpc; m_bubble = 1'b0;
                m_addr = m_hpc + 32'd4; m_held = 1'b0;
            end
        end else if (m_drain) begin
            model_bubble();
            if (imem_ready) begin
                m_drain = 1'b0; m_addr = m_target;
            end
        end else if (imem_ready) begin
            if (stall) begin
                m_held = 1'b1; m_hword = mem_word(m_addr); m_hpc = m_addr;
            end else begin
                m_instr = mem_word(m_addr); m_pcout = m_addr; m_bubble = 1'b0;
                m_addr = m_addr + 32'd4;
            end
        end else if (!stall) begin
            model_bubble();
        end
    endtask

    // drive one cycle of inputs at the falling edge, return at the next falling edge
    task automatic tick(input logic st, input logic rd, input logic [31:0] rp, input logic rdy);
        stall = st; redirect = rd; redirect_pc = rp; imem_ready = rdy;
        model_step();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (instr_out !== T_NOP) begin failures++; $display("FAIL rst_instr got %h exp %h", instr_out, T_NOP); end
        checks++; if (pc_out !== 32'd0) begin failures++; $display("FAIL rst_pc_out got %h exp 0", pc_out); end
        checks++; if (succ !== 1'b1) begin failures++; $display("FAIL rst_succ got %b exp 1", succ); end
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rel_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== T_RESET_PC) begin failures++; $display("FAIL rel_addr got %h exp %h", imem_addr, T_RESET_PC); end
        @(negedge clock);
    endtask

    task automatic test_stream();
        logic [31:0] a;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            a = T_RESET_PC + 32'(4 * i);
            checks++; if (imem_addr !== a) begin failures++; $display("FAIL str_addr %0d got %h exp %h", i, imem_addr, a); end
            tick(1'b0, 1'b0, 32'd0, 1'b1);
            checks++; if (instr_out !== mem_word(a) || pc_out !== a || succ !== 1'b0) begin
                failures++; $display("FAIL str_out %0d got %h/%h/%b exp %h/%h/0", i, instr_out, pc_out, succ, mem_word(a), a);
            end
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 32'd0, 1'b0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
                failures++; $display("FAIL ws_addr %0d got %b/%h exp 1/00400004", i, imem_req, imem_addr);
            end
            checks++; if (instr_out !== T_NOP || pc_out !== 32'd0 || succ !== 1'b1) begin
                failures++; $display("FAIL ws_bubble %0d got %h/%h/%b", i, instr_out, pc_out, succ);
            end
        end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        checks++; if (instr_out !== mem_word(32'h0040_0004) || pc_out !== 32'h0040_0004 || succ !== 1'b0) begin
            failures++; $display("FAIL ws_word got %h/%h/%b exp %h/00400004/0", instr_out, pc_out, succ, mem_word(32'h0040_0004));
        end
    endtask

    task automatic test_stall();
        apply_reset();
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 32'd0, (i == 0));
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stl_req %0d got %b exp 0", i, imem_req); end
            checks++; if (instr_out !== mem_word(32'h0040_0004) || pc_out !== 32'h0040_0004 || succ !== 1'b0) begin
                failures++; $display("FAIL stl_frozen %0d got %h/%h/%b", i, instr_out, pc_out, succ);
            end
        end
        tick(1'b0, 1'b0, 32'd0, 1'b0);
        checks++; if (instr_out !== mem_word(32'h0040_0008) || pc_out !== 32'h0040_0008 || succ !== 1'b0) begin
            failures++; $display("FAIL stl_release got %h/%h/%b exp %h/00400008/0", instr_out, pc_out, succ, mem_word(32'h0040_0008));
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000C) begin
            failures++; $display("FAIL stl_next got %b/%h exp 1/0040000c", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_pending();
        apply_reset();
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b1, 32'h0040_0102, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
                failures++; $display("FAIL rdp_hold %0d got %b/%h exp 1/00400004", i, imem_req, imem_addr);
            end
            checks++; if (succ !== 1'b1 || instr_out !== T_NOP) begin failures++; $display("FAIL rdp_bubble %0d got %h/%b", i, instr_out, succ); end
            if (i == 0) tick(1'b0, 1'b0, 32'd0, 1'b0);
        end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        checks++; if (imem_addr !== 32'h0040_0100) begin failures++; $display("FAIL rdp_target got %h exp 00400100", imem_addr); end
        checks++; if (succ !== 1'b1 || pc_out !== 32'd0) begin failures++; $display("FAIL rdp_discard got %h/%b exp 0/1", pc_out, succ); end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        checks++; if (instr_out !== mem_word(32'h0040_0100) || pc_out !== 32'h0040_0100 || succ !== 1'b0) begin
            failures++; $display("FAIL rdp_word got %h/%h/%b", instr_out, pc_out, succ);
        end
    endtask

    task automatic test_redirect_held();
        apply_reset();
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        tick(1'b1, 1'b1, 32'h0040_0200, 1'b0);
        checks++; if (instr_out !== T_NOP || pc_out !== 32'd0 || succ !== 1'b1) begin
            failures++; $display("FAIL rdh_bubble got %h/%h/%b", instr_out, pc_out, succ);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin
            failures++; $display("FAIL rdh_addr got %b/%h exp 1/00400200", imem_req, imem_addr);
        end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        checks++; if (instr_out !== mem_word(32'h0040_0200) || pc_out !== 32'h0040_0200) begin
            failures++; $display("FAIL rdh_word got %h/%h", instr_out, pc_out);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || succ !== 1'b1) begin
            failures++; $display("FAIL wrap_target got %h/%b exp fffffffc/1", imem_addr, succ);
        end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        checks++; if (imem_addr !== 32'd0 || pc_out !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_next got %h/%h exp 00000000/fffffffc", imem_addr, pc_out);
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b1, 32'h0040_0300, 1'b0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b1, 32'h0040_0400, 1'b0);
        reset = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_out !== T_NOP || pc_out !== 32'd0 || succ !== 1'b1) begin
            failures++; $display("FAIL rmd_async got %b/%h/%h/%b", imem_req, instr_out, pc_out, succ);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== T_RESET_PC) begin
            failures++; $display("FAIL rmd_restart got %b/%h exp 1/00400000", imem_req, imem_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        logic st, rd, rdy;
        logic [31:0] rp;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rdy = !m_held && ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 11) == 0) && !(m_drain && rdy);
            rp  = $urandom();
            tick(st, rd, rp, rdy);
            checks++; if (imem_req !== !m_held) begin failures++; $display("FAIL rnd_req %0d got %b exp %b", i, imem_req, !m_held); end
            if (!m_held) begin
                checks++; if (imem_addr !== m_addr) begin failures++; $display("FAIL rnd_addr %0d got %h exp %h", i, imem_addr, m_addr); end
            end
            checks++; if (instr_out !== m_instr) begin failures++; $display("FAIL rnd_instr %0d got %h exp %h", i, instr_out, m_instr); end
            checks++; if (pc_out !== m_pcout) begin failures++; $display("FAIL rnd_pc_out %0d got %h exp %h", i, pc_out, m_pcout); end
            checks++; if (succ !== m_bubble) begin failures++; $display("FAIL rnd_succ %0d got %b exp %b", i, succ, m_bubble); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_redirect_held();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
